uart_packet_sequencer: RTL and testbench

UART_PACKET_SEQUENCER -- requirements
Module: uart_packet_sequencer

---
 rtl/uart_packet_sequencer_pkg.sv | 31 +++
 rtl/uart_packet_sequencer_if.sv | 44 ++++
 rtl/uart_packet_sequencer_timer.sv | 46 ++++
 rtl/uart_packet_sequencer.sv | 153 +++++++++++++++
 tb/tb_uart_packet_sequencer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_packet_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// bpsk_pkg
// Shared definitions for the UART-to-BPSK packet path: the sequencer state
// encoding, the default packet length, the byte type and a helper that turns
// a packet length in bits into a whole number of bytes.
// -----------------------------------------------------------------------------
package bpsk_pkg;

    // Default packet length in bits
    localparam int PACKET_SIZE_DEFAULT = 64;

    // Saturation value of the dropped-byte counter
    localparam logic [7:0] DROP_MAX = 8'hFF;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COLLECT  = 3'd1,
        ST_FLUSH    = 3'd2,
        ST_LAUNCH   = 3'd3,
        ST_TRANSMIT = 3'd4,
        ST_CLEAR    = 3'd5
    } seq_state_e;

    // Number of bytes needed to hold a packet of the given bit length
    function automatic int bytes_for_bits(input int bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/uart_packet_sequencer_if.sv
// -----------------------------------------------------------------------------
// uart_packet_sequencer_if
// Bundles the sequencer's UART receive side, modulator handshake and packet
// buffer controls.
//   rx_valid/rx_byte    : received UART byte strobe and data
//   mod_ready/mod_done  : modulator idle level and end-of-packet strobe
//   buf_write/buf_byte  : packet buffer write strobe and data
//   buf_clear           : packet buffer index clear strobe
//   pkt_start           : modulator start strobe
//   busy                : sequencer not idle
//   err_timeout         : partial packet discarded on inter-byte timeout
//   err_overrun         : byte dropped while not accepting
//   drop_count          : saturating count of dropped bytes
// Modport master is the sequencer itself, slave is its environment.
// -----------------------------------------------------------------------------
interface uart_packet_sequencer_if;
    import bpsk_pkg::*;

    logic       rx_valid;
    byte_t      rx_byte;
    logic       mod_ready;
    logic       mod_done;
    logic       buf_write;
    byte_t      buf_byte;
    logic       buf_clear;
    logic       pkt_start;
    logic       busy;
    logic       err_timeout;
    logic       err_overrun;
    logic [7:0] drop_count;

    modport master (
        input  rx_valid, rx_byte, mod_ready, mod_done,
        output buf_write, buf_byte, buf_clear, pkt_start, busy,
               err_timeout, err_overrun, drop_count
    );

    modport slave (
        output rx_valid, rx_byte, mod_ready, mod_done,
        input  buf_write, buf_byte, buf_clear, pkt_start, busy,
               err_timeout, err_overrun, drop_count
    );

endinterface

// File: rtl/uart_packet_sequencer_timer.sv
// -----------------------------------------------------------------------------
// byte_timeout_timer
// Counts idle cycles between bytes of one packet.
//   clk, rst_n : clock and asynchronous active-low reset
//   kick       : restart the count from zero (has priority over enable)
//   enable     : count this cycle
//   expired    : counting and the count has reached BYTE_TIMEOUT-1
// -----------------------------------------------------------------------------
module byte_timeout_timer #(
    parameter int BYTE_TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic kick,
    input  logic enable,
    output logic expired
);

    localparam int TW = $clog2(BYTE_TIMEOUT);
    localparam logic [TW-1:0] LAST = TW'(BYTE_TIMEOUT - 1);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    // Holding at the last value keeps the count from wrapping if the owner
    // leaves it enabled one cycle too long.
    always_comb begin
        timer_d = timer_q;
        if (kick) begin
            timer_d = '0;
        end else if (enable && (timer_q != LAST)) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign expired = enable && (timer_q == LAST);

endmodule

// File: rtl/uart_packet_sequencer.sv
// -----------------------------------------------------------------------------
// uart_packet_sequencer
// Collects UART bytes into a packet buffer, commits the buffer with a trailing
// zero write, hands the packet to the BPSK modulator and clears the buffer
// when the modulator finishes. Partial packets are discarded when the gap
// between bytes gets too long, and bytes arriving while a packet is in flight
// are dropped and counted.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : uart_packet_sequencer_if.master (UART, modulator, buffer signals)
// -----------------------------------------------------------------------------
module uart_packet_sequencer
    import bpsk_pkg::*;
#(
    parameter int PACKET_SIZE  = PACKET_SIZE_DEFAULT,
    parameter int BYTE_TIMEOUT = 1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    uart_packet_sequencer_if.master   bus
);

    localparam int NBYTES = bytes_for_bits(PACKET_SIZE);
    localparam int CW     = $clog2(NBYTES + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(NBYTES);

    seq_state_e  state_q, state_d;
    logic [CW-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]  drop_count_q, drop_count_d;

    logic        rx_valid;
    logic        buf_write;
    byte_t       buf_byte;
    logic        buf_clear;
    logic        pkt_start;
    logic        err_timeout;
    logic        err_overrun;
    logic        timer_kick;
    logic        timer_en;
    logic        timer_expired;

    // The buffer write path is a combinational pass-through of rx_valid, so
    // the strobe is qualified with rst_n to keep every strobe low while reset
    // is held, even if a byte is presented at that time.
    assign rx_valid = bus.rx_valid & rst_n;

    byte_timeout_timer #(
        .BYTE_TIMEOUT (BYTE_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .kick    (timer_kick),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    // Next-state and output decode. The timer only runs in COLLECT on cycles
    // without a byte, so a byte on the expiry cycle wins over the timeout.
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        drop_count_d = drop_count_q;
        buf_write    = 1'b0;
        buf_byte     = '0;
        buf_clear    = 1'b0;
        pkt_start    = 1'b0;
        err_timeout  = 1'b0;
        err_overrun  = 1'b0;
        timer_kick   = 1'b1;
        timer_en     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    buf_write  = 1'b1;
                    buf_byte   = bus.rx_byte;
                    byte_cnt_d = CW'(1);
                    state_d    = (NBYTES == 1) ? ST_FLUSH : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                timer_kick = rx_valid;
                timer_en   = !rx_valid;
                if (rx_valid) begin
                    buf_write  = 1'b1;
                    buf_byte   = bus.rx_byte;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_d == LAST_CNT) begin
                        state_d = ST_FLUSH;
                    end
                end else if (timer_expired) begin
                    err_timeout = 1'b1;
                    state_d     = ST_CLEAR;
                end
            end
            ST_FLUSH: begin
                // Zero write commits the collected bytes to the packet
                buf_write = 1'b1;
                buf_byte  = 8'h00;
                state_d   = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                if (bus.mod_ready) begin
                    pkt_start = 1'b1;
                    state_d   = ST_TRANSMIT;
                end
            end
            ST_TRANSMIT: begin
                if (bus.mod_done) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                buf_clear  = 1'b1;
                byte_cnt_d = '0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Anything arriving once the packet is closed is dropped and counted
        if (rx_valid && (state_q != ST_IDLE) && (state_q != ST_COLLECT)) begin
            err_overrun = 1'b1;
            if (drop_count_q != DROP_MAX) begin
                drop_count_d = drop_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            byte_cnt_q   <= '0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign bus.buf_write   = buf_write;
    assign bus.buf_byte    = buf_byte;
    assign bus.buf_clear   = buf_clear;
    assign bus.pkt_start   = pkt_start;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.err_timeout = err_timeout;
    assign bus.err_overrun = err_overrun;
    assign bus.drop_count  = drop_count_q;

endmodule

// File: tb/tb_uart_packet_sequencer.sv
// -----------------------------------------------------------------------------
// tb_uart_packet_sequencer
// Drives packets, timeouts, overruns and a mid-packet reset into the sequencer
// (16-bit packets, 20-cycle byte timeout). Each scenario predicts the cycle
// and value of every buffer write, start, clear and timeout event from the
// packet rules, and a monitor records what the design actually did.
// -----------------------------------------------------------------------------
module tb_uart_packet_sequencer;

    localparam int PS = 16;
    localparam int TO = 20;
    localparam int NB = (PS + 7) / 8;

    logic clk;
    logic rst_n;
    int   cyc = 0;

    uart_packet_sequencer_if sif ();

    uart_packet_sequencer #(
        .PACKET_SIZE  (PS),
        .BYTE_TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    int compared   = 0;
    int mismatched = 0;
    int dropTotal  = 0;

    int expWrCyc[$],  obsWrCyc[$];
    int expWrByte[$], obsWrByte[$];
    int expStart[$],  obsStart[$];
    int expClear[$],  obsClear[$];
    int expTimeout[$], obsTimeout[$];
    int expOverrun  = 0;
    int obsOverrun  = 0;
    int collisions  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (sif.buf_write) begin
            obsWrCyc.push_back(cyc);
            obsWrByte.push_back(int'(sif.buf_byte));
        end
        if (sif.pkt_start)   obsStart.push_back(cyc);
        if (sif.buf_clear)   obsClear.push_back(cyc);
        if (sif.err_timeout) obsTimeout.push_back(cyc);
        if (sif.err_overrun) obsOverrun++;
        if (int'(sif.buf_write) + int'(sif.buf_clear) + int'(sif.pkt_start) > 1)
            collisions++;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic compareList(input string tag, input int obs[$], input int exp[$]);
        checkOutput({tag, ".count"}, obs.size(), exp.size());
        for (int i = 0; i < exp.size() && i < obs.size(); i++)
            checkOutput($sformatf("%s[%0d]", tag, i), obs[i], exp[i]);
    endtask

    // Compare everything the monitor saw since the last call, then start over
    task automatic checkEvents(input string tag);
        compareList({tag, ".wrCycle"}, obsWrCyc, expWrCyc);
        compareList({tag, ".wrByte"}, obsWrByte, expWrByte);
        compareList({tag, ".start"}, obsStart, expStart);
        compareList({tag, ".clear"}, obsClear, expClear);
        compareList({tag, ".timeout"}, obsTimeout, expTimeout);
        checkOutput({tag, ".overruns"}, obsOverrun, expOverrun);
        checkOutput({tag, ".strobeOverlap"}, collisions, 0);
        expWrCyc.delete();  obsWrCyc.delete();
        expWrByte.delete(); obsWrByte.delete();
        expStart.delete();  obsStart.delete();
        expClear.delete();  obsClear.delete();
        expTimeout.delete(); obsTimeout.delete();
        expOverrun = 0; obsOverrun = 0; collisions = 0;
    endtask

    // Start a new cycle: strobes default low, levels are kept
    task automatic tick();
        @(posedge clk);
        #1;
        sif.rx_valid = 1'b0;
        sif.mod_done = 1'b0;
    endtask

    // One full packet. gap < 0 picks a random legal inter-byte gap; the
    // longest legal gap is TO-1 idle cycles (next byte on the expiry cycle).
    // mod_ready rises after rd cycles past the last byte, mod_done comes dd
    // cycles after pkt_start, and up to maxDrops bytes are thrown in every
    // dropEvery cycles while the packet is in flight.
    task automatic applyStimulus(input string tag, input logic [NB*8-1:0] pkt, input int gap,
                                 input int rd, input int dd, input int dropEvery,
                                 input int maxDrops);
        int tLast, ks, total, drops, g;
        drops = 0;
        tLast = 0;
        for (int i = 0; i < NB; i++) begin
            if (i == 0) g = int'($urandom_range(0, 3));
            else g = (gap < 0) ? int'($urandom_range(0, TO - 1)) : gap;
            repeat (g) tick();
            tick();
            sif.rx_valid = 1'b1;
            sif.rx_byte  = pkt[i*8 +: 8];
            expWrCyc.push_back(cyc);
            expWrByte.push_back(int'(pkt[i*8 +: 8]));
            tLast = cyc;
        end
        expWrCyc.push_back(tLast + 1);
        expWrByte.push_back(0);
        ks = (rd + 1 > 2) ? rd + 1 : 2;
        expStart.push_back(tLast + ks);
        expClear.push_back(tLast + ks + dd + 1);
        total = ks + dd + 1;
        for (int k = 1; k <= total; k++) begin
            tick();
            sif.mod_ready = (k > rd);
            if (k == 1 || k == ks + dd) sif.mod_done = 1'b1;
            if (drops < maxDrops && (k % dropEvery) == 0) begin
                sif.rx_valid = 1'b1;
                sif.rx_byte  = 8'($urandom);
                drops++;
            end
            if (k == 1) begin
                @(negedge clk);
                checkOutput({tag, ".busyFlush"}, int'(sif.busy), 1);
            end
        end
        dropTotal += drops;
        expOverrun = drops;
        tick();
        sif.mod_done = 1'b1;
        @(negedge clk);
        #1;
        checkOutput({tag, ".busyIdle"}, int'(sif.busy), 0);
        checkOutput({tag, ".dropCount"}, int'(sif.drop_count),
                    (dropTotal > 255) ? 255 : dropTotal);
        checkEvents(tag);
    endtask

    // One byte followed by silence: timeout TO cycles later, clear after it
    task automatic applyTimeout(input string tag, input logic [7:0] b);
        int t;
        tick();
        sif.rx_valid = 1'b1;
        sif.rx_byte  = b;
        t = cyc;
        expWrCyc.push_back(t);
        expWrByte.push_back(int'(b));
        expTimeout.push_back(t + TO);
        expClear.push_back(t + TO + 1);
        repeat (TO + 2) begin
            tick();
            sif.mod_ready = 1'($urandom);
            sif.mod_done  = 1'($urandom);
        end
        @(negedge clk);
        #1;
        checkOutput({tag, ".busyIdle"}, int'(sif.busy), 0);
        checkEvents(tag);
    endtask

    // Asynchronous reset between edges while a packet is half collected
    task automatic applyReset(input logic [7:0] b);
        tick();
        sif.rx_valid = 1'b1;
        sif.rx_byte  = b;
        expWrCyc.push_back(cyc);
        expWrByte.push_back(int'(b));
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        sif.rx_valid  = 1'b1;
        sif.rx_byte   = 8'hFF;
        sif.mod_ready = 1'b1;
        #1;
        checkOutput("rst.busy", int'(sif.busy), 0);
        checkOutput("rst.bufWrite", int'(sif.buf_write), 0);
        checkOutput("rst.bufByte", int'(sif.buf_byte), 0);
        checkOutput("rst.bufClear", int'(sif.buf_clear), 0);
        checkOutput("rst.errOverrun", int'(sif.err_overrun), 0);
        checkOutput("rst.dropCount", int'(sif.drop_count), 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        sif.rx_valid = 1'b0;
        dropTotal = 0;
        expOverrun = 0;
        @(negedge clk);
        #1;
        checkEvents("rst");
    endtask

    initial begin
        rst_n = 1'b0;
        sif.rx_valid  = 1'b0;
        sif.rx_byte   = 8'h00;
        sif.mod_ready = 1'b0;
        sif.mod_done  = 1'b0;
        #2;
        checkOutput("init.busy", int'(sif.busy), 0);
        checkOutput("init.bufByte", int'(sif.buf_byte), 0);
        checkOutput("init.dropCount", int'(sif.drop_count), 0);
        checkOutput("init.pktStart", int'(sif.pkt_start), 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;

        $display("[TB] basic packet A5,3C");
        applyStimulus("basic", 16'h3CA5, 9, 0, 5, 1, 0);

        $display("[TB] inter-byte timeout");
        applyTimeout("timeout", 8'h5A);

        $display("[TB] byte on the expiry cycle");
        applyStimulus("maxGap", 16'hC381, TO - 1, 0, 3, 1, 0);

        $display("[TB] modulator held busy with overruns");
        applyStimulus("launchWait", 16'h1234, 2, 50, 4, 10, 3);

        $display("[TB] randomized packets");
        for (int n = 0; n < 8; n++) begin
            applyStimulus($sformatf("rnd%0d", n), (NB*8)'($urandom), -1,
                          int'($urandom_range(0, 6)), int'($urandom_range(1, 8)),
                          int'($urandom_range(1, 5)), int'($urandom_range(0, 3)));
            if (n % 3 == 1) applyTimeout($sformatf("rndTo%0d", n), 8'($urandom));
        end

        $display("[TB] drop counter saturation");
        applyStimulus("saturate", 16'hBEEF, 4, 0, 310, 1, 300);

        $display("[TB] reset mid-collect");
        applyReset(8'h77);
        applyStimulus("afterReset", 16'h0F1E, 5, 1, 2, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
